// File: rtl/bean_scheduler.sv
// Obstacle scheduler: scrolls, retires and spawns beans in a fixed slot pool and sequences RUN/HIT.
// Latency: every output is registered and updates on the clk edge that samples frame_tick/start/check_hit.
// Backpressure: none; the renderer only reads the slots, and a spawn with no free slot retries on later ticks.
module bean_scheduler #(
  parameter int          NUM_SLOTS = 3,
  parameter int          X_W       = 10,
  parameter int          SPAWN_X   = 700,
  parameter int          SHIFT     = 5,
  parameter int          MIN_GAP   = 150,
  parameter logic [7:0]  GAP_MASK  = 8'hFF,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_tick,
  input  logic                     i_start,
  input  logic                     i_check_hit,
  output logic [NUM_SLOTS*X_W-1:0] o_slot_x,
  output logic [NUM_SLOTS-1:0]     o_slot_type,
  output logic [NUM_SLOTS-1:0]     o_slot_valid,
  output logic [1:0]               o_state,
  output logic [15:0]              o_passed_count,
  output logic                     o_passed_pulse
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [X_W-1:0] LP_SPAWN_X = X_W'(SPAWN_X);
  localparam logic [X_W-1:0] LP_SHIFT_X = X_W'(SHIFT);
  localparam logic [9:0]     LP_SHIFT_G = 10'(SHIFT);
  localparam logic [9:0]     LP_MIN_GAP = 10'(MIN_GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HIT  = 2'b10
  } state_t;

  state_t               r_state;
  logic [X_W-1:0]       r_x [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_type;
  logic [NUM_SLOTS-1:0] r_valid;
  logic [15:0]          r_passed;
  logic                 r_pulse;
  logic [9:0]           r_gap;
  logic [7:0]           r_lfsr;

  logic [X_W-1:0]       w_x_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_type_nxt;
  logic [NUM_SLOTS-1:0] w_valid_nxt;
  logic [CW-1:0]        w_retire_n;
  logic [9:0]           w_gap_dec;
  logic [9:0]           w_gap_nxt;
  logic                 w_spawned;
  logic [16:0]          w_passed_sum;
  logic [15:0]          w_passed_nxt;

  // Free-running pattern source for gap length and bean type, independent of game state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // One frame step: scroll/retire, count, shrink gap, then drop a new bean into the lowest free slot
  always_comb begin
    w_x_nxt     = r_x;
    w_type_nxt  = r_type;
    w_valid_nxt = r_valid;
    w_retire_n  = '0;
    w_spawned   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_valid[i]) begin
        if (r_x[i] > LP_SHIFT_X) begin
          w_x_nxt[i] = r_x[i] - LP_SHIFT_X;
        end else begin
          w_x_nxt[i]     = '0;
          w_valid_nxt[i] = 1'b0;
          w_retire_n     = w_retire_n + CW'(1);
        end
      end
    end
    w_gap_dec = (r_gap > LP_SHIFT_G) ? (r_gap - LP_SHIFT_G) : 10'd0;
    // Slots freed by this tick's retirement are eligible; spawned beans skip the scroll above
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((w_gap_dec == 10'd0) && !w_spawned && !w_valid_nxt[i]) begin
        w_x_nxt[i]     = LP_SPAWN_X;
        w_type_nxt[i]  = r_lfsr[0];
        w_valid_nxt[i] = 1'b1;
        w_spawned      = 1'b1;
      end
    end
    w_gap_nxt    = w_spawned ? (LP_MIN_GAP + {2'b00, r_lfsr & GAP_MASK}) : w_gap_dec;
    w_passed_sum = {1'b0, r_passed} + 17'(w_retire_n);
    w_passed_nxt = w_passed_sum[16] ? 16'hFFFF : w_passed_sum[15:0];
  end

  // Game FSM: start (from IDLE or HIT) clears the field, RUN advances on ticks, a hit freezes everything
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_type   <= '0;
      r_valid  <= '0;
      r_passed <= '0;
      r_pulse  <= 1'b0;
      r_gap    <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_x[i] <= '0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE, S_HIT: begin
          if (i_start) begin
            r_state  <= S_RUN;
            r_type   <= '0;
            r_valid  <= '0;
            r_passed <= '0;
            r_gap    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_x[i] <= '0;
          end
        end
        S_RUN: begin
          if (i_check_hit) begin
            r_state <= S_HIT;
          end else if (i_frame_tick) begin
            r_x      <= w_x_nxt;
            r_type   <= w_type_nxt;
            r_valid  <= w_valid_nxt;
            r_passed <= w_passed_nxt;
            r_pulse  <= (w_retire_n != '0);
            r_gap    <= w_gap_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot_out
    assign o_slot_x[g*X_W +: X_W] = r_x[g];
  end

  assign o_slot_type    = r_type;
  assign o_slot_valid   = r_valid;
  assign o_state        = r_state;
  assign o_passed_count = r_passed;
  assign o_passed_pulse = r_pulse;

endmodule
